imem_port_arbiter: RTL

Shares the single-port instruction memory between the CPU fetch path (IF stage PC) and the ring NIC (program load / memory inspection over the NoC). It grants at most one access per cycle, with fetch favoured and a bounded-wait guarantee for the NIC. It also generates the CPU stall and routes the one-cycle-latency read data back to the requester that issued the access. An optional boot-hold phase keeps the CPU off the memory until the NIC has loaded the program.

---
 rtl/imem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - instruction memory port arbiter between CPU fetch and ring NIC (optional IMEM_BOOT_HOLD_EN)
module imem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_stall,
  input  logic              nic_req,
  input  logic              nic_we,
  input  logic [ADDR_W-1:0] nic_addr,
  input  logic [DATA_W-1:0] nic_wdata,
  output logic              nic_gnt,
  output logic              nic_valid,
  output logic [DATA_W-1:0] nic_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_BOOT_HOLD_EN
  ,
  input  logic              boot_done
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_NIC} owner_t;

  owner_t            owner_q, owner_d;
  logic              nic_read_q, nic_read_d;
  logic [3:0]        nic_wait_q, nic_wait_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic [DATA_W-1:0] nic_rdata_q, nic_rdata_d;
  logic              run;

  // Byte-offset bits are not used for word addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[1:0], nic_addr[1:0]};

`ifdef IMEM_BOOT_HOLD_EN
  typedef enum logic {ST_BOOT, ST_RUN} state_t;
  state_t state_q, state_d;

  // Boot-hold state register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Leave BOOT once the NIC reports the program loaded; RUN is terminal.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = ST_BOOT;
    end else if (state_q == ST_BOOT && boot_done) begin
      state_d = ST_RUN;
    end
  end

  assign run = (state_q == ST_RUN);
`else
  assign run = 1'b1;
`endif

  // Grants: fetch wins unless the NIC has waited its limit; nothing granted in reset.
  always_comb begin
    nic_gnt   = 1'b0;
    fetch_gnt = 1'b0;
    if (!reset) begin
      nic_gnt   = nic_req & (~(fetch_req & run) | (nic_wait_q == WAIT_MAX));
      fetch_gnt = run & fetch_req & ~nic_gnt;
    end
  end

  // Memory port driven from whichever requester holds the grant.
  always_comb begin
    mem_en    = fetch_gnt | nic_gnt;
    mem_we    = nic_gnt & nic_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_addr = fetch_addr[ADDR_W-1:2];
    end else if (nic_gnt) begin
      mem_addr  = nic_addr[ADDR_W-1:2];
      mem_wdata = nic_wdata;
    end
  end

  assign cpu_stall = fetch_req & ~fetch_gnt;

  // Response routing; a flush or a reset cycle suppresses the in-flight response.
  always_comb begin
    fetch_valid = ~reset & (owner_q == OWN_FETCH) & ~fetch_flush;
    nic_valid   = ~reset & (owner_q == OWN_NIC);
    fetch_data  = fetch_valid ? mem_rdata : fetch_data_q;
    nic_rdata   = (nic_valid & nic_read_q) ? mem_rdata : nic_rdata_q;
  end

  // Next-state for owner, wait counter and held response data.
  always_comb begin
    owner_d      = OWN_NONE;
    nic_read_d   = 1'b0;
    nic_wait_d   = 4'd0;
    fetch_data_d = fetch_data;
    nic_rdata_d  = nic_rdata;
    if (reset) begin
      fetch_data_d = '0;
      nic_rdata_d  = '0;
    end else begin
      if (fetch_gnt) begin
        owner_d = OWN_FETCH;
      end else if (nic_gnt) begin
        owner_d    = OWN_NIC;
        nic_read_d = ~nic_we;
      end
      if (nic_req && !nic_gnt) begin
        nic_wait_d = (nic_wait_q < WAIT_MAX) ? nic_wait_q + 4'd1 : nic_wait_q;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    owner_q      <= owner_d;
    nic_read_q   <= nic_read_d;
    nic_wait_q   <= nic_wait_d;
    fetch_data_q <= fetch_data_d;
    nic_rdata_q  <= nic_rdata_d;
  end

endmodule
